lab3_sys_onchip_mem_arbiter: RTL and testbench
==============================================

// Module: lab3_sys_onchip_mem_arbiter
// PURPOSE
//  Two-master round-robin arbiter for the single-port 32-bit on-chip RAM in lab3_sys.
//  Lets m0 (CPU data port) and m1 (DMA/test port) share the RAM, one access per clk.
//  Presents Avalon-MM pipelined slaves to the masters and drives one s1-style master into the RAM.
//  The RAM has unregistered q and registered inputs, so read data arrives one clk after the access.
// PARAMETERS
//  ADDR_W     14     word address width, for both the masters and the RAM
//  DATA_W     32     data width
//  BE_W       4      byteenable width (DATA_W/8)
//  NUM_WORDS  10000  populated RAM words; addresses >= NUM_WORDS are out of range
// PORTS
//  clk                clock  in   1       single clock domain
//  reset              reset  in   1       asynchronous, active-high
//  mN_address         in     ADDR_W   master N (N=0,1) word address
//  mN_byteenable      in     BE_W     master N byte lanes
//  mN_read            in     1        master N read request
//  mN_write           in     1        master N write request
//  mN_writedata       in     DATA_W   master N write data
//  mN_waitrequest     out    1        master N stalled; hold request stable
//  mN_readdata        out    DATA_W   master N read data
//  mN_readdatavalid   out    1        master N read data valid (1 clk pulse)
//  mem_address        out    ADDR_W   to RAM address
//  mem_byteenable     out    BE_W     to RAM byteenable
//  mem_chipselect     out    1        to RAM chipselect
//  mem_write          out    1        to RAM write
//  mem_writedata      out    DATA_W   to RAM writedata
//  mem_clken          out    1        to RAM clken; tied 1
//  mem_readdata       in     DATA_W   from RAM q (valid 1 clk after the read access)
//  oor_err            out    1        sticky out-of-range or illegal-request flag
// BEHAVIOUR
//  - Reset values (async assert):
//    - rr_ptr=0, so m0 has priority first.
//    - mN_readdatavalid=0, mN_readdata=0, oor_err=0.
//    - rsp_pend=0, rsp_id=0.
//    - mN_waitrequest=1 while reset is high.
//  - Request: reqN = mN_read | mN_write.
//  - Grant is combinational from reqN and rr_ptr:
//    - One requester: it wins.
//    - Both requesting: the master selected by rr_ptr wins.
//  - Waitrequest: mN_waitrequest = reqN & ~grantN. A grant means accepted this clk.
//  - Pointer update: on any grant, rr_ptr <= ~winner. No master waits more than one access.
//  - Mem side is a combinational mux of the winner's signals.
//    - mem_chipselect = grant & in_range.
//    - mem_write = winner write.
//  - Read response:
//    - A granted read sets rsp_pend=1 and rsp_id=winner.
//    - Next clk: m[rsp_id]_readdata <= mem_readdata and m[rsp_id]_readdatavalid=1.
//    - Latency: exactly 1 clk after acceptance.
//    - Back-to-back reads are allowed; throughput is 1 access/clk.
//  - Writes complete in the accept clk and produce no response.
//  - Out of range (address >= NUM_WORDS):
//    - Accepted with mem_chipselect=0.
//    - A read returns 0 with readdatavalid still asserted.
//    - oor_err is set.
//  - Illegal request (read & write together from one master): executed as a write, read ignored, oor_err set.
//  - oor_err clears only on reset.
//  - Reset mid-read: the pending response is discarded; no readdatavalid after reset deassertion.
//  - Write then read of the same address on consecutive clks returns the new data.
// CONFIGURATION
//  LAB3_ARB_LOCK_EN defined:
//  - Adds inputs mN_lock (1b).
//  - While the last winner holds mN_lock=1, rr_ptr freezes and the other master sees waitrequest=1.
//  - The lock releases the clk mN_lock drops.
//  - If both masters assert lock, the current owner keeps the RAM.
//  LAB3_ARB_LOCK_EN undefined:
//  - No lock ports; pure round-robin every clk.
// STRUCTURE
//  - Package lab3_arb_pkg:
//    - typedef master_id_t (1b).
//    - localparams M0=0 and M1=1.
//    - localparam RD_LATENCY=1.
//  - Sub-module lab3_rr_arbiter2: reqN and rr_ptr (plus lock) in; grant one-hot and winner id out.
//  - Top holds the request mux, range check, response pipe and oor_err.
// TESTING
//  1. Reset: assert reset mid-read.
//     -> readdatavalid=0, readdata=0, oor_err=0, both waitrequest=1 while reset is high.
//  2. Single master: m0 writes 0xDEADBEEF to 0x0010, then reads 0x0010 next clk.
//     -> m0_readdatavalid one clk later with 0xDEADBEEF.
//  3. Contention: m0 and m1 each hold a read for 4 clks.
//     -> grants alternate m0,m1,m0,m1; each waits at most 1 clk.
//  4. Byte lanes: write 0xFFFFFFFF, then be=4'b0010 data=0x00000000, then read.
//     -> read returns 0xFFFF00FF.
//  5. Range: read at address 10000.
//     -> readdata=0 with valid, mem_chipselect=0, oor_err=1 until reset.
//  6. LAB3_ARB_LOCK_EN: m1 locks for 3 accesses while m0 requests.
//     -> m0 is stalled 3 clks, then granted.

Source files
------------

// File: rtl/lab3_arb_pkg.sv
// lab3_arb_pkg: master ids and timing constants shared by the on-chip RAM arbiter.
package lab3_arb_pkg;
    typedef logic master_id_t;
    localparam master_id_t M0 = 1'b0;
    localparam master_id_t M1 = 1'b1;
    localparam int RD_LATENCY = 1;
endpackage

// File: rtl/lab3_rr_arbiter2.sv
// lab3_rr_arbiter2: two-way round-robin grant, with an owner hold when LAB3_ARB_LOCK_EN is defined.
module lab3_rr_arbiter2
    import lab3_arb_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  master_id_t rr_ptr,
`ifdef LAB3_ARB_LOCK_EN
    input  logic       hold,
    input  master_id_t owner,
`endif
    output logic [1:0] grant,
    output master_id_t winner
);
    logic [1:0] req;
`ifdef LAB3_ARB_LOCK_EN
    // a held lock hides the non-owner from arbitration entirely
    assign req = hold ? (owner == M1 ? {req1, 1'b0} : {1'b0, req0}) : {req1, req0};
`else
    assign req = {req1, req0};
`endif
    assign winner = &req ? rr_ptr : master_id_t'(req[1]);
    assign grant  = {req[1] & (winner == M1), req[0] & (winner == M0)};
endmodule

// File: rtl/lab3_sys_onchip_mem_arbiter.sv
// lab3_sys_onchip_mem_arbiter: round-robin sharing of the single-port on-chip RAM between m0 and m1.
// Define LAB3_ARB_LOCK_EN to add mN_lock inputs that let the last winner keep the RAM.
module lab3_sys_onchip_mem_arbiter
    import lab3_arb_pkg::*;
#(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 32,
    parameter int BE_W      = 4,
    parameter int NUM_WORDS = 10000
)(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
`ifdef LAB3_ARB_LOCK_EN
    input  logic              m0_lock,
    input  logic              m1_lock,
`endif
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic              oor_err
);
    logic              req0, req1, any_grant, w_read, w_write, in_range;
    logic              rsp_pend, rsp_oor;
    logic [1:0]        grant;
    logic [ADDR_W-1:0] w_addr;
    master_id_t        rr_ptr, winner, rsp_id;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

`ifdef LAB3_ARB_LOCK_EN
    master_id_t owner;
    logic       owner_vld, hold;
    assign hold = owner_vld & (owner == M1 ? m1_lock : m0_lock);

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            owner     <= M0;
            owner_vld <= 1'b0;
        end else if (any_grant) begin
            owner     <= winner;
            owner_vld <= 1'b1;
        end
`endif

    lab3_rr_arbiter2 u_arb (
        .req0   (req0),
        .req1   (req1),
        .rr_ptr (rr_ptr),
`ifdef LAB3_ARB_LOCK_EN
        .hold   (hold),
        .owner  (owner),
`endif
        .grant  (grant),
        .winner (winner)
    );

    assign any_grant      = |grant;
    assign w_addr         = winner == M1 ? m1_address : m0_address;
    assign w_read         = winner == M1 ? m1_read : m0_read;
    assign w_write        = winner == M1 ? m1_write : m0_write;
    assign in_range       = 32'(w_addr) < NUM_WORDS;
    assign m0_waitrequest = reset | (req0 & ~grant[0]);
    assign m1_waitrequest = reset | (req1 & ~grant[1]);
    assign mem_address    = w_addr;
    assign mem_byteenable = winner == M1 ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = winner == M1 ? m1_writedata : m0_writedata;
    assign mem_chipselect = any_grant & in_range;
    assign mem_write      = w_write;
    assign mem_clken      = 1'b1;

    // RAM q is valid the clk after the access, so one pending slot covers back-to-back reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr           <= M0;
            rsp_pend         <= 1'b0;
            rsp_id           <= M0;
            rsp_oor          <= 1'b0;
            oor_err          <= 1'b0;
            m0_readdata      <= '0;
            m1_readdata      <= '0;
            m0_readdatavalid <= 1'b0;
            m1_readdatavalid <= 1'b0;
        end else begin
`ifdef LAB3_ARB_LOCK_EN
            if (any_grant && !hold) rr_ptr <= ~winner;
`else
            if (any_grant) rr_ptr <= ~winner;
`endif
            rsp_pend         <= any_grant & w_read & ~w_write;
            rsp_id           <= winner;
            rsp_oor          <= ~in_range;
            m0_readdatavalid <= rsp_pend & (rsp_id == M0);
            m1_readdatavalid <= rsp_pend & (rsp_id == M1);
            if (rsp_pend && rsp_id == M0) m0_readdata <= rsp_oor ? '0 : mem_readdata;
            if (rsp_pend && rsp_id == M1) m1_readdata <= rsp_oor ? '0 : mem_readdata;
            if (any_grant && (!in_range || (w_read && w_write))) oor_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lab3_sys_onchip_mem_arbiter.sv
// tb_lab3_sys_onchip_mem_arbiter: scoreboard bench for the on-chip RAM arbiter with a behavioural RAM.
module tb_lab3_sys_onchip_mem_arbiter;
    import lab3_arb_pkg::*;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [13:0] m0_address, m1_address, mem_address;
    logic [3:0]  m0_byteenable, m1_byteenable, mem_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata;
    logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic        mem_chipselect, mem_write, mem_clken, oor_err;
    logic [31:0] mem_writedata, mem_readdata;
`ifdef LAB3_ARB_LOCK_EN
    logic        m0_lock = 1'b0, m1_lock = 1'b0;
`endif

    int          checks = 0, passed = 0, cyc = 0;
    exp_t        q0[$], q1[$];
    logic [31:0] ref_mem [0:16383];
    logic [31:0] ram [0:16383];
    logic [13:0] ram_addr_q;

    lab3_sys_onchip_mem_arbiter dut (
        .clk              (clk),
        .reset            (reset),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
`ifdef LAB3_ARB_LOCK_EN
        .m0_lock          (m0_lock),
        .m1_lock          (m1_lock),
`endif
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata),
        .oor_err          (oor_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM: registered inputs, unregistered q
    always @(posedge clk) if (mem_clken && mem_chipselect) begin
        ram_addr_q <= mem_address;
        if (mem_write)
            for (int b = 0; b < 4; b++)
                if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
    end
    assign mem_readdata = ram[ram_addr_q];

    function automatic logic [31:0] rd_exp(input logic [13:0] a);
        return (int'(a) < 10000) ? ref_mem[a] : 32'h0;
    endfunction

    task automatic ref_wr(input logic [13:0] a, input logic [3:0] be, input logic [31:0] d);
        if (int'(a) < 10000)
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic idle();
        {m0_read, m0_write, m1_read, m1_write} = 4'b0;
        m0_address = '0; m1_address = '0; m0_byteenable = 4'hF; m1_byteenable = 4'hF;
        m0_writedata = '0; m1_writedata = '0;
    endtask

    task automatic drv(input int m, input logic rd, input logic wr, input logic [13:0] a,
                       input logic [3:0] be, input logic [31:0] d);
        if (m == 0) begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
        end
    endtask

    // Advance to the sampling edge, score responses, then record newly accepted requests.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (reset) begin
            q0.delete();
            q1.delete();
            return;
        end
        if (m0_readdatavalid) begin
            checks++;
            if (q0.size() == 0) $display("FAIL m0_rsp: unexpected readdatavalid, readdata=%h", m0_readdata);
            else begin
                e = q0.pop_front();
                if (m0_readdata !== e.data || cyc != e.due)
                    $display("FAIL m0_rsp: got %h at cyc %0d, want %h at cyc %0d", m0_readdata, cyc, e.data, e.due);
                else passed++;
            end
        end
        if (m1_readdatavalid) begin
            checks++;
            if (q1.size() == 0) $display("FAIL m1_rsp: unexpected readdatavalid, readdata=%h", m1_readdata);
            else begin
                e = q1.pop_front();
                if (m1_readdata !== e.data || cyc != e.due)
                    $display("FAIL m1_rsp: got %h at cyc %0d, want %h at cyc %0d", m1_readdata, cyc, e.data, e.due);
                else passed++;
            end
        end
        if (q0.size() != 0 && q0[0].due < cyc) begin
            checks++;
            $display("FAIL m0_rsp_missing: no readdatavalid by cyc %0d, want %h at cyc %0d", cyc, q0[0].data, q0[0].due);
            void'(q0.pop_front());
        end
        if (q1.size() != 0 && q1[0].due < cyc) begin
            checks++;
            $display("FAIL m1_rsp_missing: no readdatavalid by cyc %0d, want %h at cyc %0d", cyc, q1[0].data, q1[0].due);
            void'(q1.pop_front());
        end
        if ((m0_read || m0_write) && !m0_waitrequest) begin
            if (m0_write) ref_wr(m0_address, m0_byteenable, m0_writedata);
            else q0.push_back('{rd_exp(m0_address), cyc + RD_LATENCY + 1});
        end
        if ((m1_read || m1_write) && !m1_waitrequest) begin
            if (m1_write) ref_wr(m1_address, m1_byteenable, m1_writedata);
            else q1.push_back('{rd_exp(m1_address), cyc + RD_LATENCY + 1});
        end
    endtask

    task automatic test_reset();
        idle();
        drv(0, 1, 0, 14'h10, 4'hF, 0);
        drv(1, 1, 0, 14'h20, 4'hF, 0);
        tick();
        checks++;
        if ({m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid, oor_err} !== 5'b11000 ||
            {m0_readdata, m1_readdata} !== 64'h0)
            $display("FAIL reset_state: wait=%b%b valid=%b%b oor=%b rd0=%h rd1=%h, want wait=11 valid=00 oor=0 rd=0",
                     m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid, oor_err, m0_readdata, m1_readdata);
        else passed++;
        @(posedge clk); #1; reset = 1'b0; idle();
        tick();
        checks++;
        if ({m0_waitrequest, m1_waitrequest} !== 2'b00)
            $display("FAIL idle_wait: wait=%b%b, want 00", m0_waitrequest, m1_waitrequest);
        else passed++;
    endtask

    task automatic test_single();
        @(posedge clk); #1; idle(); drv(0, 0, 1, 14'h10, 4'hF, 32'hDEADBEEF); tick();
        checks++;
        if ({m0_waitrequest, mem_chipselect, mem_write, mem_address} !== {3'b011, 14'h10})
            $display("FAIL single_wr: wait=%b cs=%b we=%b addr=%h, want 0 1 1 0010",
                     m0_waitrequest, mem_chipselect, mem_write, mem_address);
        else passed++;
        @(posedge clk); #1; drv(0, 1, 0, 14'h10, 4'hF, 0); tick();
        checks++;
        if ({m0_waitrequest, mem_chipselect, mem_write} !== 3'b010)
            $display("FAIL single_rd: wait=%b cs=%b we=%b, want 0 1 0", m0_waitrequest, mem_chipselect, mem_write);
        else passed++;
        @(posedge clk); #1; idle(); tick();
        checks++;
        if (m0_readdatavalid !== 1'b0) $display("FAIL single_early: readdatavalid=%b, want 0", m0_readdatavalid);
        else passed++;
        @(posedge clk); #1; tick();
        checks++;
        if ({m0_readdatavalid, m0_readdata} !== {1'b1, 32'hDEADBEEF})
            $display("FAIL single_data: valid=%b data=%h, want 1 deadbeef", m0_readdatavalid, m0_readdata);
        else passed++;
    endtask

    task automatic test_contention();
        @(posedge clk); #1; idle(); drv(0, 0, 1, 14'h20, 4'hF, 32'h0000A0A0); tick();
        @(posedge clk); #1; idle(); drv(1, 0, 1, 14'h30, 4'hF, 32'h0000B1B1); tick();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            drv(0, 1, 0, 14'h20, 4'hF, 0);
            drv(1, 1, 0, 14'h30, 4'hF, 0);
            tick();
            checks++;
            if ({m1_waitrequest, m0_waitrequest} !== ((i % 2 == 1) ? 2'b01 : 2'b10))
                $display("FAIL contention_%0d: wait m1,m0=%b%b, want %s winning", i, m1_waitrequest, m0_waitrequest,
                         (i % 2 == 1) ? "m1" : "m0");
            else passed++;
        end
        @(posedge clk); #1; idle(); tick();
        for (int i = 0; i < 2; i++) begin @(posedge clk); #1; tick(); end
        checks++;
        if (q0.size() != 0 || q1.size() != 0)
            $display("FAIL contention_drain: pending m0=%0d m1=%0d, want 0 0", q0.size(), q1.size());
        else passed++;
    endtask

    task automatic test_byte_lanes();
        @(posedge clk); #1; idle(); drv(1, 0, 1, 14'h40, 4'hF, 32'hFFFFFFFF); tick();
        @(posedge clk); #1; drv(1, 0, 1, 14'h40, 4'b0010, 32'h00000000); tick();
        @(posedge clk); #1; drv(1, 1, 0, 14'h40, 4'hF, 0); tick();
        @(posedge clk); #1; idle(); tick();
        @(posedge clk); #1; tick();
        checks++;
        if ({m1_readdatavalid, m1_readdata} !== {1'b1, 32'hFFFF00FF})
            $display("FAIL byte_lanes: valid=%b data=%h, want 1 ffff00ff", m1_readdatavalid, m1_readdata);
        else passed++;
    endtask

    task automatic test_range();
        checks++;
        if (oor_err !== 1'b0) $display("FAIL range_pre: oor_err=%b, want 0", oor_err);
        else passed++;
        @(posedge clk); #1; idle(); drv(0, 0, 1, 14'd9999, 4'hF, 32'h12345678); tick();
        @(posedge clk); #1; drv(0, 1, 0, 14'd9999, 4'hF, 0); tick();
        checks++;
        if ({mem_chipselect, m0_waitrequest} !== 2'b10)
            $display("FAIL range_last_word: cs=%b wait=%b, want 1 0", mem_chipselect, m0_waitrequest);
        else passed++;
        @(posedge clk); #1; drv(0, 1, 0, 14'd10000, 4'hF, 0); tick();
        checks++;
        if ({mem_chipselect, m0_waitrequest, oor_err} !== 3'b000)
            $display("FAIL range_oor_cs: cs=%b wait=%b oor=%b, want 0 0 0", mem_chipselect, m0_waitrequest, oor_err);
        else passed++;
        @(posedge clk); #1; idle(); tick();
        checks++;
        if ({oor_err, m0_readdatavalid, m0_readdata} !== {2'b11, 32'h12345678})
            $display("FAIL range_oor_set: oor=%b valid=%b data=%h, want 1 1 12345678", oor_err, m0_readdatavalid, m0_readdata);
        else passed++;
        @(posedge clk); #1; tick();
        checks++;
        if ({m0_readdatavalid, m0_readdata} !== {1'b1, 32'h0})
            $display("FAIL range_oor_data: valid=%b data=%h, want 1 00000000", m0_readdatavalid, m0_readdata);
        else passed++;
        for (int i = 0; i < 3; i++) begin @(posedge clk); #1; tick(); end
        checks++;
        if (oor_err !== 1'b1) $display("FAIL range_sticky: oor_err=%b, want 1", oor_err);
        else passed++;
    endtask

    task automatic test_reset_mid_read();
        @(posedge clk); #1; idle(); drv(0, 1, 0, 14'h10, 4'hF, 0); tick();
        @(posedge clk); #1; reset = 1'b1; drv(1, 1, 0, 14'h40, 4'hF, 0); tick();
        checks++;
        if ({m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid, oor_err} !== 5'b11000 ||
            {m0_readdata, m1_readdata} !== 64'h0)
            $display("FAIL reset_mid_read: wait=%b%b valid=%b%b oor=%b rd0=%h rd1=%h, want 11 00 0 0 0",
                     m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid, oor_err, m0_readdata, m1_readdata);
        else passed++;
        @(posedge clk); #1; tick();
        @(posedge clk); #1; reset = 1'b0; idle(); tick();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1; tick();
            checks++;
            if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00)
                $display("FAIL reset_discard_%0d: valid=%b%b, want 00", i, m0_readdatavalid, m1_readdatavalid);
            else passed++;
        end
    endtask

    task automatic test_illegal();
        checks++;
        if (oor_err !== 1'b0) $display("FAIL illegal_pre: oor_err=%b, want 0", oor_err);
        else passed++;
        @(posedge clk); #1; idle(); drv(1, 1, 1, 14'h50, 4'hF, 32'hCAFEF00D); tick();
        checks++;
        if ({m1_waitrequest, mem_chipselect, mem_write} !== 3'b011)
            $display("FAIL illegal_as_write: wait=%b cs=%b we=%b, want 0 1 1", m1_waitrequest, mem_chipselect, mem_write);
        else passed++;
        @(posedge clk); #1; idle(); tick();
        @(posedge clk); #1; tick();
        checks++;
        if ({oor_err, m1_readdatavalid} !== 2'b10)
            $display("FAIL illegal_flag: oor=%b valid=%b, want 1 0", oor_err, m1_readdatavalid);
        else passed++;
        @(posedge clk); #1; drv(1, 1, 0, 14'h50, 4'hF, 0); tick();
        @(posedge clk); #1; idle(); tick();
        @(posedge clk); #1; tick();
        checks++;
        if ({m1_readdatavalid, m1_readdata} !== {1'b1, 32'hCAFEF00D})
            $display("FAIL illegal_data: valid=%b data=%h, want 1 cafef00d", m1_readdatavalid, m1_readdata);
        else passed++;
    endtask

`ifdef LAB3_ARB_LOCK_EN
    task automatic test_lock();
        @(posedge clk); #1; idle(); m1_lock = 1'b1; drv(1, 1, 0, 14'h50, 4'hF, 0); tick();
        checks++;
        if (m1_waitrequest !== 1'b0) $display("FAIL lock_take: m1 wait=%b, want 0", m1_waitrequest);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            drv(0, 1, 0, 14'h10, 4'hF, 0);
            drv(1, 1, 0, 14'h50, 4'hF, 0);
            tick();
            checks++;
            if ({m1_waitrequest, m0_waitrequest} !== 2'b01)
                $display("FAIL lock_hold_%0d: wait m1,m0=%b%b, want 01", i, m1_waitrequest, m0_waitrequest);
            else passed++;
        end
        @(posedge clk); #1; m1_lock = 1'b0; tick();
        checks++;
        if ({m1_waitrequest, m0_waitrequest} !== 2'b10)
            $display("FAIL lock_release: wait m1,m0=%b%b, want 10", m1_waitrequest, m0_waitrequest);
        else passed++;
        @(posedge clk); #1; idle(); tick();
        for (int i = 0; i < 2; i++) begin @(posedge clk); #1; tick(); end
        checks++;
        if (q0.size() != 0 || q1.size() != 0)
            $display("FAIL lock_drain: pending m0=%0d m1=%0d, want 0 0", q0.size(), q1.size());
        else passed++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_byte_lanes();
        test_range();
        test_reset_mid_read();
        test_illegal();
`ifdef LAB3_ARB_LOCK_EN
        test_lock();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
